// File: rtl/mult_4_bit_seq.sv
// Sequential shift-add unsigned multiplier: WIDTH add-shift steps per product,
// with back-to-back restart from DONE and fully asynchronous clear.
module mult_4_bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic               last_step_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] step_s;

  assign accept_s    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_step_s = (state_q == ST_CALC) && (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CALC;
        else       state_d = ST_IDLE;
      end
      ST_CALC: begin
        if (last_step_s) state_d = ST_DONE;
        else             state_d = ST_CALC;
      end
      ST_DONE: begin
        if (start) state_d = ST_CALC;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin busy_d = 1'b0; done_d = 1'b0; end
      ST_CALC: begin busy_d = 1'b1; done_d = 1'b0; end
      ST_DONE: begin busy_d = 1'b0; done_d = 1'b1; end
      default: begin busy_d = 1'b0; done_d = 1'b0; end
    endcase
  end

  // One add-shift step; the adder carry becomes the new accumulator MSB
  always_comb begin
    if (acc_q[0]) begin
      sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end else begin
      sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    step_s = {sum_s, acc_q[WIDTH-1:1]};
  end

  // Datapath next-state: capture on accepted start, step in CALC, else hold
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept_s) begin
      mcand_d = a;
      acc_d   = {{WIDTH{1'b0}}, b};
      cnt_d   = {CNT_W{1'b0}};
    end else if (state_q == ST_CALC) begin
      acc_d = step_s;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step_s) begin
        product_d = step_s;
      end else begin
        product_d = product_q;
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      product_q <= {(2*WIDTH){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
